// File: rtl/dmem_io_pkg.sv
// Shared constants and helpers for the data-memory I/O bridge.
// The IO_HEX_DECODE_EN build uses hex_to_seg; the default build stores raw segments.
package dmem_io_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OFS_W  = 4;
  localparam int unsigned SEG_W  = 7;

  localparam logic [DATA_W-1:0] IO_BASE_DEFAULT = 16'hFFF0;

  localparam logic [OFS_W-1:0] DISP_OFS = 4'h0;
  localparam logic [OFS_W-1:0] SW_OFS   = 4'h2;
  localparam logic [OFS_W-1:0] EVT_OFS  = 4'h4;

  // Hex digit to active-low 7-segment pattern, bit order gfedcba.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] digit);
    logic [SEG_W-1:0] seg;
    case (digit)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/dmem_io_bridge_switch_debounce.sv
// Two-flop synchronizer plus stability counter for one slide switch.
// change_pulse is combinational and is high in the cycle whose edge updates db_out.
module switch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_in,
  output logic db_out,
  output logic change_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;
  logic             differs;

  assign differs      = (sync_b != db_out);
  assign change_pulse = differs && (cnt == CNT_MAX);

  // Synchronize the pin, count consecutive differing cycles, accept when stable long enough.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      db_out <= 1'b0;
    end else begin
      sync_a <= pin_in;
      sync_b <= sync_a;
      if (change_pulse) begin
        db_out <= sync_b;
        cnt    <= '0;
      end else if (differs) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dmem_io_bridge.sv
// Memory-mapped I/O bridge: steers PMIPSL0 data accesses to RAM or to the
// display / switch / event registers in the IO_BASE window.
// Optional macro IO_HEX_DECODE_EN: DISP holds a hex digit decoded to segments.
module dmem_io_bridge
  import dmem_io_pkg::*;
#(
  parameter int unsigned       DEBOUNCE_CYCLES = 50000,
  parameter logic [DATA_W-1:0] IO_BASE         = IO_BASE_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemwdata,
  input  logic              dmemwrite,
  input  logic              dmemread,
  output logic [DATA_W-1:0] dmemrdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              io_sw0,
  input  logic              io_sw1,
  output logic [SEG_W-1:0]  io_display
);

  logic              io_sel;
  logic [OFS_W-1:0]  offset;
  logic              disp_we;
  logic              evt_clr;
  logic              sw0_db;
  logic              sw1_db;
  logic              sw0_chg;
  logic              sw1_chg;
  logic [1:0]        evt;
  logic [DATA_W-1:0] disp_rd;
  logic [DATA_W-1:0] io_rdata;

  assign offset  = dmemaddr[OFS_W-1:0];
  assign io_sel  = (dmemaddr[DATA_W-1:OFS_W] == IO_BASE[DATA_W-1:OFS_W]);
  assign ram_we  = dmemwrite & ~io_sel;
  assign ram_re  = dmemread & ~io_sel;
  assign disp_we = dmemwrite & io_sel & (offset == DISP_OFS);
  assign evt_clr = dmemread & io_sel & (offset == EVT_OFS);

`ifdef IO_HEX_DECODE_EN
  logic [3:0] digit;
  logic       unused_wdata;

  assign unused_wdata = ^dmemwdata[DATA_W-1:4];
  assign disp_rd      = {12'b0, digit};

  // Hex digit latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      digit <= 4'h0;
    end else if (disp_we) begin
      digit <= dmemwdata[3:0];
    end
  end

  // Registered segment decode of the digit.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_display <= hex_to_seg(4'h0);
    end else begin
      io_display <= hex_to_seg(digit);
    end
  end
`else
  logic [SEG_W-1:0] disp_reg;
  logic             unused_wdata;

  assign unused_wdata = ^dmemwdata[DATA_W-1:SEG_W];
  assign disp_rd      = {9'b0, disp_reg};

  // Raw segment latch; reset blanks the display.
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_reg <= 7'h7F;
    end else if (disp_we) begin
      disp_reg <= dmemwdata[SEG_W-1:0];
    end
  end

  // Output register for the segment pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_display <= 7'h7F;
    end else begin
      io_display <= disp_reg;
    end
  end
`endif

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw0 (
    .clock        (clock),
    .reset        (reset),
    .pin_in       (io_sw0),
    .db_out       (sw0_db),
    .change_pulse (sw0_chg)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
    .clock        (clock),
    .reset        (reset),
    .pin_in       (io_sw1),
    .db_out       (sw1_db),
    .change_pulse (sw1_chg)
  );

  // Sticky change events; a new event beats a read-clear on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      evt <= 2'b00;
    end else begin
      evt <= (evt & {2{~evt_clr}}) | {sw1_chg, sw0_chg};
    end
  end

  // I/O register read mux.
  always_comb begin
    io_rdata = '0;
    case (offset)
      DISP_OFS: io_rdata = disp_rd;
      SW_OFS:   io_rdata = {14'b0, sw1_db, sw0_db};
      EVT_OFS:  io_rdata = {14'b0, evt};
      default:  io_rdata = '0;
    endcase
  end

  // Read data back to the processor; zero when not reading.
  always_comb begin
    dmemrdata = '0;
    if (dmemread) begin
      dmemrdata = io_sel ? io_rdata : ram_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Directed bench for dmem_io_bridge with DEBOUNCE_CYCLES=4, IO_BASE=16'hFFF0.
module tb_dmem_io_bridge;

  localparam int unsigned DC = 4;

`ifdef IO_HEX_DECODE_EN
  localparam logic [6:0]  RST_DISP = 7'h40;
  localparam logic [15:0] RB_RST   = 16'h0000;
  localparam logic [15:0] RB_24    = 16'h0004;
  localparam logic [15:0] RB_1B    = 16'h000B;
  localparam logic [6:0]  DISP_24  = 7'h19;
  localparam logic [6:0]  DISP_1B  = 7'h03;
`else
  localparam logic [6:0]  RST_DISP = 7'h7F;
  localparam logic [15:0] RB_RST   = 16'h007F;
  localparam logic [15:0] RB_24    = 16'h0024;
  localparam logic [15:0] RB_1B    = 16'h001B;
  localparam logic [6:0]  DISP_24  = 7'h24;
  localparam logic [6:0]  DISP_1B  = 7'h1B;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] dmemaddr;
  logic [15:0] dmemwdata;
  logic        dmemwrite;
  logic        dmemread;
  logic [15:0] dmemrdata;
  logic        ram_we;
  logic        ram_re;
  logic [15:0] ram_rdata;
  logic        io_sw0;
  logic        io_sw1;
  logic [6:0]  io_display;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  dmem_io_bridge #(.DEBOUNCE_CYCLES(DC), .IO_BASE(16'hFFF0)) dut (
    .clock      (clock),
    .reset      (reset),
    .dmemaddr   (dmemaddr),
    .dmemwdata  (dmemwdata),
    .dmemwrite  (dmemwrite),
    .dmemread   (dmemread),
    .dmemrdata  (dmemrdata),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_rdata  (ram_rdata),
    .io_sw0     (io_sw0),
    .io_sw1     (io_sw1),
    .io_display (io_display)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
    logic [15:0] ram;
    logic [15:0] exp_rdata;
    logic        exp_ram_we;
    logic        exp_ram_re;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic bus(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
    dmemaddr  = a;
    dmemwdata = d;
    dmemwrite = w;
    dmemread  = r;
  endtask

  initial begin
    vecs[0]  = '{16'hFFF0, 16'h0000, 1'b0, 1'b1, 16'h1111, RB_24,    1'b0, 1'b0};
    vecs[1]  = '{16'hFFF2, 16'h0000, 1'b0, 1'b1, 16'h2222, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{16'hFFF4, 16'h0000, 1'b0, 1'b1, 16'h3333, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{16'h0010, 16'h0000, 1'b0, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b1};
    vecs[4]  = '{16'h0010, 16'h0055, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{16'hFFF0, 16'h0000, 1'b0, 1'b1, 16'h0000, RB_24,    1'b0, 1'b0};
    vecs[6]  = '{16'hFFF8, 16'h0000, 1'b0, 1'b1, 16'h4444, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{16'hFFF6, 16'h00FF, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{16'hFFEF, 16'h0000, 1'b0, 1'b1, 16'h0F0F, 16'h0F0F, 1'b0, 1'b1};
    vecs[9]  = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h5555, 16'h0000, 1'b0, 1'b0};
    vecs[10] = '{16'hFFF0, 16'h001B, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{16'hFFF0, 16'h0000, 1'b0, 1'b1, 16'h0000, RB_1B,    1'b0, 1'b0};
    vecs[12] = '{16'h0020, 16'h0000, 1'b0, 1'b0, 16'hABCD, 16'h0000, 1'b0, 1'b0};

    reset     = 1'b1;
    io_sw0    = 1'b0;
    io_sw1    = 1'b0;
    ram_rdata = 16'h0000;
    bus(16'h0000, 16'h0000, 1'b0, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    cyc();
    chk("reset display", 16'(io_display), 16'(RST_DISP));
    bus(16'hFFF2, 16'h0000, 1'b0, 1'b1);
    #1 chk("reset sw", dmemrdata, 16'h0000);
    bus(16'hFFF4, 16'h0000, 1'b0, 1'b1);
    #1 chk("reset evt", dmemrdata, 16'h0000);
    @(negedge clock);

    // Display write latency: unchanged after the write edge, updated one edge later.
    bus(16'hFFF0, 16'h0024, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    bus(16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("disp lag edge1", 16'(io_display), 16'(RST_DISP));
    @(posedge clock);
    #1 chk("disp lag edge2", 16'(io_display), 16'(DISP_24));
    @(negedge clock);

    // Decode and read-mux vectors.
    for (int i = 0; i < 13; i++) begin
      bus(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re);
      ram_rdata = vecs[i].ram;
      #2;
      chk($sformatf("vec%0d rdata", i), dmemrdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d ram_we", i), 16'(ram_we), 16'(vecs[i].exp_ram_we));
      chk($sformatf("vec%0d ram_re", i), 16'(ram_re), 16'(vecs[i].exp_ram_re));
      cyc();
    end
    cyc();
    chk("disp after table", 16'(io_display), 16'(DISP_1B));

    // sw0 rise: debounced value appears on edge 2+DC.
    io_sw0 = 1'b1;
    bus(16'hFFF2, 16'h0000, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("sw0 rise edge%0d", k), dmemrdata, (k >= 6) ? 16'h0001 : 16'h0000);
    end
    bus(16'hFFF4, 16'h0000, 1'b0, 1'b1);
    #1 chk("evt0 set", dmemrdata, 16'h0001);
    cyc();
    chk("evt0 cleared", dmemrdata, 16'h0000);

    // sw1 glitch of 2 cycles: filtered out.
    io_sw1 = 1'b1;
    cyc();
    cyc();
    io_sw1 = 1'b0;
    repeat (8) cyc();
    bus(16'hFFF2, 16'h0000, 1'b0, 1'b1);
    #1 chk("glitch sw", dmemrdata, 16'h0001);
    bus(16'hFFF4, 16'h0000, 1'b0, 1'b1);
    #1 chk("glitch evt", dmemrdata, 16'h0000);
    @(negedge clock);

    // EVT read-clear on the same edge sw1 becomes debounced: set wins.
    io_sw1 = 1'b1;
    bus(16'hFFF2, 16'h0000, 1'b0, 1'b1);
    repeat (5) cyc();
    chk("sw1 before db", dmemrdata, 16'h0001);
    bus(16'hFFF4, 16'h0000, 1'b0, 1'b1);
    #1 chk("evt before db", dmemrdata, 16'h0000);
    cyc();
    chk("evt1 set wins", dmemrdata, 16'h0002);
    cyc();
    chk("evt1 cleared", dmemrdata, 16'h0000);
    bus(16'hFFF2, 16'h0000, 1'b0, 1'b1);
    #1 chk("both sw high", dmemrdata, 16'h0003);
    @(negedge clock);

    // Return switches low, then reset everything.
    io_sw0 = 1'b0;
    io_sw1 = 1'b0;
    repeat (8) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus(16'hFFF4, 16'h0000, 1'b0, 1'b1);
    #1 chk("post reset evt", dmemrdata, 16'h0000);
    bus(16'hFFF0, 16'h0000, 1'b0, 1'b1);
    #1 chk("post reset disp rb", dmemrdata, RB_RST);
    chk("post reset display", 16'(io_display), 16'(RST_DISP));
    @(negedge clock);

    // Reset two cycles into a sw0 debounce restarts the full settle.
    io_sw0 = 1'b1;
    bus(16'hFFF2, 16'h0000, 1'b0, 1'b1);
    repeat (4) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid reset sw", dmemrdata, 16'h0000);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("sw0 after reset edge%0d", k), dmemrdata, (k >= 6) ? 16'h0001 : 16'h0000);
    end
    bus(16'hFFF4, 16'h0000, 1'b0, 1'b1);
    #1 chk("evt0 after reset settle", dmemrdata, 16'h0001);
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
